cc_lanespeed_timer: RTL and testbench

Multi-lane, programmable speed-tick generator for the Frogger object-motion path. It replaces the single fixed-constant speed comparator with LANES independent counters, one per traffic lane. Each counter has a runtime-loadable limit and produces a one-cycle active-low tick, and a level-up pulse sequentially accelerates every lane with a saturating floor. Ticks feed the lane shift registers.

---
 rtl/cc_lanespeed_pkg.sv | 21 ++
 rtl/cc_lanespeed_lane.sv | 36 +++
 rtl/cc_lanespeed_timer.sv | 100 ++++++++++
 tb/tb_cc_lanespeed_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cc_lanespeed_pkg.sv
// rtl/cc_lanespeed_pkg.sv - shared types, defaults and limit-step helper for cc_lanespeed_timer
package cc_lanespeed_pkg;

    typedef enum logic {IDLE, SCAN} speedState_t;

    localparam int          CC_DATAWIDTH     = 24;
    localparam int          CC_LANES         = 4;
    localparam int unsigned CC_DEFAULT_LIMIT = 16500000;
    localparam int unsigned CC_MIN_LIMIT     = 1000000;
    localparam int unsigned CC_SHIFT         = 3;

    // One level-up step: shave limit>>shift off the limit, never going below the floor.
    function automatic logic [31:0] speedStep(input logic [31:0] limit,
                                              input int unsigned shift,
                                              input logic [31:0] floorLimit);
        logic [31:0] reduced;
        reduced = limit - (limit >> shift);
        return (reduced < floorLimit) ? floorLimit : reduced;
    endfunction

endpackage

// File: rtl/cc_lanespeed_lane.sv
// rtl/cc_lanespeed_lane.sv - one lane: free-running counter, limit compare and registered active-low tick
module cc_lanespeed_lane
    import cc_lanespeed_pkg::*;
#(
    parameter int DATAWIDTH = CC_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DATAWIDTH-1:0] limit,
    output logic                 tickLow
);

    logic [DATAWIDTH-1:0] count;

    // >= rather than == so a limit lowered under the running count still fires instead of wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            tickLow <= 1'b1;
        end else if (clear) begin
            count   <= '0;
            tickLow <= 1'b1;
        end else if (run && (count >= limit)) begin
            count   <= '0;
            tickLow <= 1'b0;
        end else if (run) begin
            count   <= count + 1'b1;
            tickLow <= 1'b1;
        end else begin
            tickLow <= 1'b1;
        end
    end

endmodule

// File: rtl/cc_lanespeed_timer.sv
// rtl/cc_lanespeed_timer.sv - per-lane programmable speed ticks with a sequential level-up scan
module cc_lanespeed_timer
    import cc_lanespeed_pkg::*;
#(
    parameter int          DATAWIDTH     = CC_DATAWIDTH,
    parameter int          LANES         = CC_LANES,
    parameter int unsigned DEFAULT_LIMIT = CC_DEFAULT_LIMIT,
    parameter int unsigned MIN_LIMIT     = CC_MIN_LIMIT,
    parameter int unsigned SHIFT         = CC_SHIFT
) (
    input  logic                       CC_LANESPEED_CLOCK_50,
    input  logic                       CC_LANESPEED_RESET_InLow,
    input  logic                       CC_LANESPEED_Run_In,
    input  logic                       CC_LANESPEED_Clear_In,
    input  logic                       CC_LANESPEED_Wr_In,
    input  logic [$clog2(LANES)-1:0]   CC_LANESPEED_WrLane_InBUS,
    input  logic [DATAWIDTH-1:0]       CC_LANESPEED_WrData_InBUS,
    input  logic                       CC_LANESPEED_SpeedUp_In,
    output logic [LANES-1:0]           CC_LANESPEED_Tick_OutBUSLow,
    output logic                       CC_LANESPEED_Busy_Out
);

    localparam int LW = $clog2(LANES);
    localparam logic [DATAWIDTH-1:0] DEF_LIMIT = DATAWIDTH'(DEFAULT_LIMIT);
    localparam logic [DATAWIDTH-1:0] MIN_L     = DATAWIDTH'(MIN_LIMIT);

    logic [DATAWIDTH-1:0] limitReg  [LANES];
    logic [DATAWIDTH-1:0] stepLimit [LANES];
    logic [DATAWIDTH-1:0] wrClamped;
    logic [LANES-1:0]     wrHit;
    speedState_t          state;
    logic [LW-1:0]        idx;

    // Lane decode only matches real lanes, so out-of-range write indices fall through untouched.
    always_comb begin
        wrClamped = (CC_LANESPEED_WrData_InBUS < MIN_L) ? MIN_L : CC_LANESPEED_WrData_InBUS;
        for (int i = 0; i < LANES; i++) begin
            stepLimit[i] = DATAWIDTH'(speedStep(32'(limitReg[i]), SHIFT, 32'(MIN_L)));
            wrHit[i]     = CC_LANESPEED_Wr_In && (CC_LANESPEED_WrLane_InBUS == LW'(i));
        end
    end

    // A host write outranks the scan step on the same lane in the same cycle.
    always_ff @(posedge CC_LANESPEED_CLOCK_50) begin
        for (int i = 0; i < LANES; i++) begin
            if (!CC_LANESPEED_RESET_InLow) begin
                limitReg[i] <= DEF_LIMIT;
            end else if (wrHit[i]) begin
                limitReg[i] <= wrClamped;
            end else if ((state == SCAN) && (idx == LW'(i))) begin
                limitReg[i] <= stepLimit[i];
            end
        end
    end

    always_ff @(posedge CC_LANESPEED_CLOCK_50) begin
        if (!CC_LANESPEED_RESET_InLow) begin
            state                 <= IDLE;
            idx                   <= '0;
            CC_LANESPEED_Busy_Out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CC_LANESPEED_SpeedUp_In) begin
                        state                 <= SCAN;
                        idx                   <= '0;
                        CC_LANESPEED_Busy_Out <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == LW'(LANES - 1)) begin
                        state                 <= IDLE;
                        idx                   <= '0;
                        CC_LANESPEED_Busy_Out <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state                 <= IDLE;
                    CC_LANESPEED_Busy_Out <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        cc_lanespeed_lane #(
            .DATAWIDTH(DATAWIDTH)
        ) uLane (
            .clk    (CC_LANESPEED_CLOCK_50),
            .resetn (CC_LANESPEED_RESET_InLow),
            .run    (CC_LANESPEED_Run_In),
            .clear  (CC_LANESPEED_Clear_In),
            .limit  (limitReg[g]),
            .tickLow(CC_LANESPEED_Tick_OutBUSLow[g])
        );
    end

endmodule

// File: tb/tb_cc_lanespeed_timer.sv
// tb/tb_cc_lanespeed_timer.sv - self-checking bench for cc_lanespeed_timer
module tb_cc_lanespeed_timer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic       clear;
    logic       wr;
    logic [1:0] wrLane;
    logic [7:0] wrData;
    logic       speedUp;
    logic [3:0] tick;
    logic       busy;

    always #5 clk = ~clk;

    cc_lanespeed_timer #(
        .DATAWIDTH    (8),
        .LANES        (4),
        .DEFAULT_LIMIT(9),
        .MIN_LIMIT    (4),
        .SHIFT        (1)
    ) dut (
        .CC_LANESPEED_CLOCK_50      (clk),
        .CC_LANESPEED_RESET_InLow   (resetn),
        .CC_LANESPEED_Run_In        (run),
        .CC_LANESPEED_Clear_In      (clear),
        .CC_LANESPEED_Wr_In         (wr),
        .CC_LANESPEED_WrLane_InBUS  (wrLane),
        .CC_LANESPEED_WrData_InBUS  (wrData),
        .CC_LANESPEED_SpeedUp_In    (speedUp),
        .CC_LANESPEED_Tick_OutBUSLow(tick),
        .CC_LANESPEED_Busy_Out      (busy)
    );

    typedef struct {
        logic [4:0] exp;
        int         seq;
    } sbEntry_t;

    typedef struct {
        int lane;
        int data;
        int expLim;
    } wrVec_t;

    sbEntry_t sbQ[$];
    sbEntry_t ent;
    wrVec_t   wrTab[9];
    int       total = 0;
    int       bad = 0;
    int       seqNo = 0;
    int       runCnt = 0;
    int       benchLim[4];

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %0h want %0h", nm, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            ent = sbQ.pop_front();
            chk("busy_tick", ent.seq, 32'({busy, tick}), 32'(ent.exp));
        end
    end

    task automatic cyc(input logic [3:0] eTick, input logic eBusy);
        @(posedge clk);
        #1;
        seqNo++;
        sbQ.push_back('{{eBusy, eTick}, seqNo});
    endtask

    task automatic clearEdge();
        run    = 1'b1;
        clear  = 1'b1;
        runCnt = 0;
        cyc(4'hF, 1'b0);
        clear  = 1'b0;
    endtask

    task automatic runEdges(input int n, input logic r);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            run   = r;
            clear = 1'b0;
            if (r) runCnt++;
            for (int l = 0; l < 4; l++)
                e[l] = !(r && ((runCnt % (benchLim[l] + 1)) == 0));
            cyc(e, 1'b0);
        end
    endtask

    task automatic writeLimit(input int lane, input int data);
        run    = 1'b0;
        wr     = 1'b1;
        wrLane = 2'(lane);
        wrData = 8'(data);
        cyc(4'hF, 1'b0);
        wr     = 1'b0;
    endtask

    task automatic chkAll(input string nm, input int l0, input int l1, input int l2, input int l3);
        int exp[4];
        exp = '{l0, l1, l2, l3};
        for (int l = 0; l < 4; l++) chk(nm, l, 32'(dut.limitReg[l]), 32'(exp[l]));
    endtask

    initial begin
        wrTab[0] = '{0, 0, 4};
        wrTab[1] = '{1, 3, 4};
        wrTab[2] = '{3, 4, 4};
        wrTab[3] = '{2, 5, 5};
        wrTab[4] = '{1, 255, 255};
        wrTab[5] = '{0, 9, 9};
        wrTab[6] = '{1, 9, 9};
        wrTab[7] = '{3, 9, 9};
        wrTab[8] = '{2, 2, 4};
        benchLim = '{9, 9, 9, 9};

        resetn = 1'b0; run = 1'b1; clear = 1'b0; wr = 1'b0;
        wrLane = 2'd0; wrData = 8'd0; speedUp = 1'b0;
        cyc(4'hF, 1'b0);
        cyc(4'hF, 1'b0);
        chkAll("reset_limit", 9, 9, 9, 9);
        resetn = 1'b1;

        // Default period: one tick every 10 running edges on every lane.
        clearEdge();
        runEdges(30, 1'b1);

        for (int i = 0; i < 9; i++) begin
            writeLimit(wrTab[i].lane, wrTab[i].data);
            chk("wr_limit", i, 32'(dut.limitReg[wrTab[i].lane]), 32'(wrTab[i].expLim));
        end
        benchLim[2] = 4;
        clearEdge();
        runEdges(30, 1'b1);
        writeLimit(2, 9);
        benchLim[2] = 9;

        // Level-up scan 9 -> 5 lane by lane, with a pulse during the scan that must be dropped.
        run = 1'b0;
        speedUp = 1'b1;
        cyc(4'hF, 1'b1);
        speedUp = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) speedUp = 1'b1;
            cyc(4'hF, k < 4);
            speedUp = 1'b0;
            for (int l = 0; l < 4; l++)
                chk("scan_limit", k * 4 + l, 32'(dut.limitReg[l]), (l < k) ? 32'd5 : 32'd9);
        end
        cyc(4'hF, 1'b0);
        chkAll("scan_ignored", 5, 5, 5, 5);

        speedUp = 1'b1;
        cyc(4'hF, 1'b1);
        speedUp = 1'b0;
        for (int k = 1; k <= 4; k++) cyc(4'hF, k < 4);
        chkAll("scan_floor", 4, 4, 4, 4);
        benchLim = '{4, 4, 4, 4};
        clearEdge();
        runEdges(15, 1'b1);

        for (int l = 0; l < 4; l++) writeLimit(l, 9);
        benchLim = '{9, 9, 9, 9};

        // Lower lane 0 under its running count: fires on the next running edge.
        clearEdge();
        runEdges(7, 1'b1);
        writeLimit(0, 3);
        chk("lower_limit", 0, 32'(dut.limitReg[0]), 32'd4);
        run = 1'b1;
        cyc(4'b1110, 1'b0);
        cyc(4'hF, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'hF, 1'b0);
        cyc(4'hF, 1'b0);
        cyc(4'b1110, 1'b0);
        writeLimit(0, 9);

        // Pause keeps phase; clear on a due tick suppresses it and restarts from 0.
        clearEdge();
        runEdges(4, 1'b1);
        runEdges(20, 1'b0);
        runEdges(6, 1'b1);
        clearEdge();
        runEdges(9, 1'b1);
        clearEdge();
        runEdges(10, 1'b1);

        // Writes racing the scan: lane 1 written while scanned, lane 3 written before it is reached.
        run = 1'b0;
        speedUp = 1'b1;
        cyc(4'hF, 1'b1);
        speedUp = 1'b0;
        wr = 1'b1; wrLane = 2'd3; wrData = 8'd8;
        cyc(4'hF, 1'b1);
        wrLane = 2'd1; wrData = 8'd7;
        cyc(4'hF, 1'b1);
        wr = 1'b0;
        cyc(4'hF, 1'b1);
        cyc(4'hF, 1'b0);
        chkAll("scan_write", 5, 7, 5, 4);

        speedUp = 1'b1;
        cyc(4'hF, 1'b1);
        speedUp = 1'b0;
        cyc(4'hF, 1'b1);
        resetn = 1'b0;
        cyc(4'hF, 1'b0);
        chkAll("scan_reset", 9, 9, 9, 9);
        resetn = 1'b1;
        cyc(4'hF, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drain", 0, 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
